bitcoin_sha256d: RTL and testbench

Tiny-Tapeout user block that computes the Bitcoin double SHA-256 (SHA256(SHA256(header))) of an 80-byte block header. The host loads the header as 40 16-bit words over the dedicated and bidirectional pins, using a request handshake. The hash is computed iteratively, one round per cycle. The 32-byte digest is then returned one byte per handshake over the bidirectional pins.

---
 rtl/bitcoin_sha256d.sv | 205 ++++++++++++++++++++
 tb/tb_bitcoin_sha256d.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bitcoin_sha256d.sv
// Bitcoin double SHA-256 of an 80-byte header: 16-bit word load handshake, one
// compression round per cycle, digest returned a byte at a time over a four-phase handshake.
module bitcoin_sha256d (
    input  logic       clk,
    input  logic       rst,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);
    typedef enum logic [2:0] {
        StLoadRq, StLoadGap, StInit, StRound, StFinal, StOutRq, StOutAckLow, StEnd
    } state_e;

    localparam logic [255:0] IV = {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                                   32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    state_e       state_q, state_d;
    logic [639:0] block, block_d;
    logic [255:0] h_q, h_d, h_sum;
    logic [31:0]  wv_q [8];
    logic [31:0]  wv_d [8];
    logic [31:0]  w_q [16];
    logic [31:0]  w_d [16];
    logic [5:0]   addr_q, addr_d, rnd_q, rnd_d;
    logic [1:0]   comp_q, comp_d;
    logic         rq_q, rq_d, done_q, done_d;
    logic [31:0]  t1, t2, w_next;
    logic         ack;
    logic         unused_ena;

    function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
        return (x >> n) | (x << (32 - n));
    endfunction

    assign ack        = ui_in[7];
    assign unused_ena = ena;

    always_comb begin
        t1 = wv_q[7] + (rotr(wv_q[4], 6) ^ rotr(wv_q[4], 11) ^ rotr(wv_q[4], 25))
           + ((wv_q[4] & wv_q[5]) ^ (~wv_q[4] & wv_q[6])) + K[rnd_q] + w_q[0];
        t2 = (rotr(wv_q[0], 2) ^ rotr(wv_q[0], 13) ^ rotr(wv_q[0], 22))
           + ((wv_q[0] & wv_q[1]) ^ (wv_q[0] & wv_q[2]) ^ (wv_q[1] & wv_q[2]));
        w_next = (rotr(w_q[14], 17) ^ rotr(w_q[14], 19) ^ (w_q[14] >> 10)) + w_q[9]
               + (rotr(w_q[1], 7) ^ rotr(w_q[1], 18) ^ (w_q[1] >> 3)) + w_q[0];
        h_sum = '0;
        for (int i = 0; i < 8; i++) begin
            h_sum[255 - 32 * i -: 32] = h_q[255 - 32 * i -: 32] + wv_q[i];
        end
    end

    always_comb begin
        state_d = state_q;
        block_d = block;
        h_d     = h_q;
        wv_d    = wv_q;
        w_d     = w_q;
        addr_d  = addr_q;
        rnd_d   = rnd_q;
        comp_d  = comp_q;
        rq_d    = rq_q;
        done_d  = done_q;
        case (state_q)
            StLoadRq: begin
                if (!rq_q) begin
                    rq_d = 1'b1;  // first cycle out of reset only
                end else begin
                    block_d[639 - 16 * addr_q -: 16] = {ui_in, uio_in};
                    rq_d = 1'b0;
                    if (addr_q == 6'd39) begin
                        addr_d  = '0;
                        comp_d  = '0;
                        state_d = StInit;
                    end else begin
                        addr_d  = addr_q + 6'd1;
                        state_d = StLoadGap;
                    end
                end
            end
            StLoadGap: begin
                rq_d    = 1'b1;
                state_d = StLoadRq;
            end
            StInit: begin
                for (int i = 0; i < 8; i++) wv_d[i] = h_q[255 - 32 * i -: 32];
                if (comp_q == 2'd0) begin
                    for (int j = 0; j < 16; j++) w_d[j] = block[639 - 32 * j -: 32];
                end else if (comp_q == 2'd1) begin
                    for (int j = 0; j < 16; j++) w_d[j] = '0;
                    for (int j = 0; j < 4; j++) w_d[j] = block[127 - 32 * j -: 32];
                    w_d[4]  = 32'h8000_0000;
                    w_d[15] = 32'h0000_0280;
                end
                rnd_d   = '0;
                state_d = StRound;
            end
            StRound: begin
                wv_d[0] = t1 + t2;
                wv_d[1] = wv_q[0];
                wv_d[2] = wv_q[1];
                wv_d[3] = wv_q[2];
                wv_d[4] = wv_q[3] + t1;
                wv_d[5] = wv_q[4];
                wv_d[6] = wv_q[5];
                wv_d[7] = wv_q[6];
                for (int j = 0; j < 15; j++) w_d[j] = w_q[j + 1];
                w_d[15] = w_next;
                rnd_d   = rnd_q + 6'd1;
                if (rnd_q == 6'd63) state_d = StFinal;
            end
            StFinal: begin
                if (comp_q == 2'd1) begin
                    // First digest is the third compression's message; H restarts at IV.
                    h_d = IV;
                    for (int j = 0; j < 8; j++) w_d[j] = h_sum[255 - 32 * j -: 32];
                    for (int j = 9; j < 15; j++) w_d[j] = '0;
                    w_d[8]  = 32'h8000_0000;
                    w_d[15] = 32'h0000_0100;
                    comp_d  = 2'd2;
                    state_d = StInit;
                end else begin
                    h_d = h_sum;
                    if (comp_q == 2'd0) begin
                        comp_d  = 2'd1;
                        state_d = StInit;
                    end else begin
                        done_d  = 1'b1;
                        rq_d    = 1'b1;
                        addr_d  = '0;
                        state_d = StOutRq;
                    end
                end
            end
            StOutRq: begin
                if (ack) begin
                    rq_d    = 1'b0;
                    addr_d  = addr_q + 6'd1;
                    state_d = StOutAckLow;
                end
            end
            StOutAckLow: begin
                if (!ack) begin
                    if (addr_q[5]) begin
                        state_d = StEnd;
                    end else begin
                        rq_d    = 1'b1;
                        state_d = StOutRq;
                    end
                end
            end
            StEnd: ;
            default: state_d = StLoadRq;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StLoadRq;
            block   <= '0;
            h_q     <= IV;
            addr_q  <= '0;
            rnd_q   <= '0;
            comp_q  <= '0;
            rq_q    <= 1'b0;
            done_q  <= 1'b0;
            for (int i = 0; i < 8; i++) wv_q[i] <= '0;
            for (int i = 0; i < 16; i++) w_q[i] <= '0;
        end else begin
            state_q <= state_d;
            block   <= block_d;
            h_q     <= h_d;
            addr_q  <= addr_d;
            rnd_q   <= rnd_d;
            comp_q  <= comp_d;
            rq_q    <= rq_d;
            done_q  <= done_d;
            for (int i = 0; i < 8; i++) wv_q[i] <= wv_d[i];
            for (int i = 0; i < 16; i++) w_q[i] <= w_d[i];
        end
    end

    assign uo_out  = {rq_q, done_q, addr_q};
    assign uio_out = (done_q && !addr_q[5]) ? h_q[255 - 8 * addr_q -: 8] : 8'h00;
    assign uio_oe  = {8{done_q}};
endmodule

// File: tb/tb_bitcoin_sha256d.sv
// Bench for bitcoin_sha256d: genesis and random headers checked against a
// generic byte-oriented SHA-256 model, with reset aborts and a slow host.
module tb_bitcoin_sha256d;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ena = 1'b1;
    logic [7:0] ui_in = '0;
    logic [7:0] uio_in = '0;
    logic [7:0] uo_out, uio_out, uio_oe;
    logic [5:0] addr;
    logic       done, rq;
    int         checks = 0;
    int         errors = 0;

    localparam logic [639:0] GENESIS = {32'h01000000, 256'h0,
        256'h3BA3EDFD7A7B12B27AC72C3E67768F617FC81BC3888A51323A9FB8AA4B1E5E4A,
        32'h29AB5F49, 32'hFFFF001D, 32'h1DAC2B7C};
    localparam logic [255:0] GEN_DIGEST =
        256'h6fe28c0ab6f1b372c1a6a246ae63f74f931e8365e15a089c68d6190000000000;
    localparam logic [31:0] KT [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1,
        32'h923f82a4, 32'hab1c5ed5, 32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174, 32'he49b69c1, 32'hefbe4786,
        32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147,
        32'h06ca6351, 32'h14292967, 32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85, 32'ha2bfe8a1, 32'ha81a664b,
        32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a,
        32'h5b9cca4f, 32'h682e6ff3, 32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    bitcoin_sha256d dut (
        .clk    (clk),
        .rst    (rst),
        .ena    (ena),
        .ui_in  (ui_in),
        .uio_in (uio_in),
        .uo_out (uo_out),
        .uio_out(uio_out),
        .uio_oe (uio_oe)
    );

    always #5 clk = ~clk;

    assign addr = uo_out[5:0];
    assign done = uo_out[6];
    assign rq   = uo_out[7];

    task automatic check(input string tag, input logic [639:0] obs, input logic [639:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // Generic FIPS 180-4 SHA-256 over an arbitrary byte string.
    function automatic logic [255:0] sha256(input byte unsigned msg [$]);
        byte unsigned m [$];
        logic [31:0]  hv [8];
        logic [31:0]  w [64];
        logic [31:0]  a, b, c, d, e, f, g, h, t1, t2, s0, s1;
        logic [63:0]  bitlen;
        logic [255:0] res;
        m = msg;
        bitlen = 64'(m.size()) * 64'd8;
        m.push_back(8'h80);
        while (m.size() % 64 != 56) m.push_back(8'h00);
        for (int i = 7; i >= 0; i--) m.push_back(bitlen[8 * i +: 8]);
        hv = '{32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
               32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
        for (int base = 0; base < m.size(); base += 64) begin
            for (int t = 0; t < 16; t++)
                w[t] = {m[base + 4 * t], m[base + 4 * t + 1], m[base + 4 * t + 2],
                        m[base + 4 * t + 3]};
            for (int t = 16; t < 64; t++) begin
                s0 = ror(w[t - 15], 7) ^ ror(w[t - 15], 18) ^ (w[t - 15] >> 3);
                s1 = ror(w[t - 2], 17) ^ ror(w[t - 2], 19) ^ (w[t - 2] >> 10);
                w[t] = w[t - 16] + s0 + w[t - 7] + s1;
            end
            a = hv[0]; b = hv[1]; c = hv[2]; d = hv[3];
            e = hv[4]; f = hv[5]; g = hv[6]; h = hv[7];
            for (int t = 0; t < 64; t++) begin
                t1 = h + (ror(e, 6) ^ ror(e, 11) ^ ror(e, 25)) + ((e & f) ^ (~e & g))
                   + KT[t] + w[t];
                t2 = (ror(a, 2) ^ ror(a, 13) ^ ror(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
                h = g; g = f; f = e; e = d + t1;
                d = c; c = b; b = a; a = t1 + t2;
            end
            hv[0] += a; hv[1] += b; hv[2] += c; hv[3] += d;
            hv[4] += e; hv[5] += f; hv[6] += g; hv[7] += h;
        end
        for (int i = 0; i < 8; i++) res[255 - 32 * i -: 32] = hv[i];
        return res;
    endfunction

    function automatic logic [255:0] sha256d(input logic [639:0] hdr);
        byte unsigned q [$];
        logic [255:0] d1;
        for (int i = 0; i < 80; i++) q.push_back(hdr[639 - 8 * i -: 8]);
        d1 = sha256(q);
        q.delete();
        for (int i = 0; i < 32; i++) q.push_back(d1[255 - 8 * i -: 8]);
        return sha256(q);
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        ui_in = '0;
        uio_in = '0;
        @(negedge clk);
        @(negedge clk);
        check("rst_uo_out", 640'(uo_out), 640'(0));
        check("rst_uio_oe", 640'(uio_oe), 640'(0));
        check("rst_uio_out", 640'(uio_out), 640'(0));
        rst = 1'b0;
    endtask

    // Host answers every request at once, so rq must toggle every cycle from the first.
    task automatic load_header(input logic [639:0] hdr, input int stop_after);
        int i;
        i = 0;
        for (int c = 0; c < 200 && i < 40; c++) begin
            @(negedge clk);
            check("load_uio_oe", 640'(uio_oe), 640'(0));
            check("load_done", 640'(done), 640'(0));
            check("load_rq_phase", 640'(rq), 640'(c % 2 == 0));
            if (rq) begin
                check("load_addr", 640'(addr), 640'(i));
                {ui_in, uio_in} = hdr[639 - 16 * i -: 16];
                if (i == stop_after) return;
                i++;
            end
        end
        check("load_complete", 640'(i), 640'(40));
    endtask

    task automatic wait_done(input logic [639:0] hdr, input logic [255:0] exp);
        int c;
        for (c = 0; c < 400; c++) begin
            @(negedge clk);
            ui_in = '0;
            uio_in = '0;
            if (done) break;
        end
        check("done_latency", 640'(c), 640'(198));
        check("done_rq", 640'(rq), 640'(1));
        check("done_addr", 640'(addr), 640'(0));
        check("done_uio_oe", 640'(uio_oe), 640'(8'hff));
        check("done_byte0", 640'(uio_out), 640'(exp[255:248]));
        check("block_reg", dut.block, hdr);
    endtask

    task automatic read_digest(input logic [255:0] exp, input int slow_byte, input int maxd);
        logic [255:0] got;
        int c, dly, hold;
        got = '0;
        for (int k = 0; k < 32; k++) begin
            c = 0;
            while (!rq && c < 20) begin
                @(negedge clk);
                c++;
            end
            check("read_rq", 640'(rq), 640'(1));
            check("read_addr", 640'(addr), 640'(k));
            got[255 - 8 * k -: 8] = uio_out;
            dly  = (k == slow_byte) ? 7 : int'($urandom_range(maxd, 0));
            hold = (k == slow_byte) ? 5 : int'($urandom_range(2, 1));
            for (int j = 0; j < dly; j++) begin
                @(negedge clk);
                check("wait_rq", 640'(rq), 640'(1));
                check("wait_addr", 640'(addr), 640'(k));
                check("wait_byte", 640'(uio_out), 640'(exp[255 - 8 * k -: 8]));
            end
            ui_in[7] = 1'b1;
            for (int j = 0; j < hold; j++) begin
                @(negedge clk);
                check("ack_rq", 640'(rq), 640'(0));
                check("ack_addr", 640'(addr), 640'(k + 1));
            end
            ui_in[7] = 1'b0;
        end
        check("digest", 640'(got), 640'(exp));
        repeat (3) begin
            @(negedge clk);
            check("end_addr", 640'(addr), 640'(32));
            check("end_rq", 640'(rq), 640'(0));
            check("end_done", 640'(done), 640'(1));
            check("end_uio_oe", 640'(uio_oe), 640'(8'hff));
            check("end_uio_out", 640'(uio_out), 640'(0));
        end
    endtask

    initial begin
        logic [639:0] hdr;
        logic [255:0] exp;

        do_reset();
        load_header(GENESIS, -1);
        wait_done(GENESIS, GEN_DIGEST);
        read_digest(GEN_DIGEST, 5, 0);

        // Abort mid-hash, then a full rerun must reproduce the digest.
        do_reset();
        load_header(GENESIS, -1);
        repeat (100) @(negedge clk);
        check("midhash_done", 640'(done), 640'(0));
        do_reset();
        load_header(GENESIS, -1);
        wait_done(GENESIS, GEN_DIGEST);
        read_digest(GEN_DIGEST, -1, 1);

        // Abort after word 17 has been sampled.
        do_reset();
        load_header(GENESIS, 17);
        @(negedge clk);
        do_reset();
        load_header(GENESIS, -1);
        wait_done(GENESIS, GEN_DIGEST);
        read_digest(GEN_DIGEST, -1, 2);

        for (int r = 0; r < 3; r++) begin
            for (int j = 0; j < 20; j++) hdr[639 - 32 * j -: 32] = $urandom();
            exp = sha256d(hdr);
            do_reset();
            load_header(hdr, -1);
            wait_done(hdr, exp);
            read_digest(exp, -1, 3);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
